// File: rtl/ntcrack_pkg.sv
// Shared constants and FSM encoding for the NT-hash cracker front end.
package ntcrack_pkg;
  localparam int HASH_BYTES_DEFAULT = 16;
  localparam int HASH_BITS          = 128;

  typedef enum logic [1:0] {
    ST_LOADING = 2'd0,
    ST_FULL    = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;
endpackage

// File: rtl/ntcrack_input_sync.sv
// Asynchronous pin -> synchroniser -> optional debounce -> registered rise pulse.
// Optional feature: define NTCRACK_HASH_LOADER_DEBOUNCE_EN to require DEBOUNCE_CYCLES
// identical synchronised samples before a level change is accepted.
module ntcrack_input_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise
);
  // Reject configurations that cannot work at elaboration time.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("ntcrack_input_sync: SYNC_STAGES must be >=2 and DEBOUNCE_CYCLES >=1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   level_q;
  logic                   rise_q;

  // Metastability chain; pin enters at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

`ifdef NTCRACK_HASH_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt;
  logic          db_level;

  // Count consecutive samples disagreeing with the accepted level; flip when enough seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_level <= sync_q[SYNC_STAGES-1];
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  // Registered rising-edge detector so the pulse is a clean single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level;
      rise_q  <= level & ~level_q;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/ntcrack_hash_loader.sv
// Host-facing loader: assembles strobed bytes into the target hash and launches the cracker.
// Optional feature: NTCRACK_HASH_LOADER_DEBOUNCE_EN adds input debouncing (see ntcrack_input_sync).
module ntcrack_hash_loader
  import ntcrack_pkg::*;
#(
  parameter int HASH_BYTES      = HASH_BYTES_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           new_hash_byte,
  input  logic                 store_hash_byte,
  input  logic                 go,
  input  logic                 cracker_busy,
  output logic [HASH_BITS-1:0] target_hash,
  output logic                 hash_valid,
  output logic                 start,
  output logic [4:0]           byte_count,
  output logic                 load_error
);
  state_t     state_q, state_d;
  logic       store_edge, go_edge;
  logic       wr_byte, fire, err_set, done;
  logic       busy_seen;
  logic [1:0] wait_cnt;

  ntcrack_input_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store_sync (
    .clk(clk), .reset(reset), .pin(store_hash_byte), .rise(store_edge)
  );

  ntcrack_input_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_sync (
    .clk(clk), .reset(reset), .pin(go), .rise(go_edge)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LOADING;
    else       state_q <= state_d;
  end

  // Next state and per-cycle actions; store wins in LOADING, go wins in FULL.
  always_comb begin
    state_d = state_q;
    wr_byte = 1'b0;
    fire    = 1'b0;
    err_set = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_LOADING: begin
        if (store_edge) begin
          wr_byte = 1'b1;
          if (byte_count == 5'(HASH_BYTES - 1)) state_d = ST_FULL;
        end
        if (go_edge) err_set = 1'b1;
      end
      ST_FULL: begin
        if (go_edge && !cracker_busy) begin
          fire    = 1'b1;
          state_d = ST_RUNNING;
        end else if (go_edge) begin
          err_set = 1'b1;
        end
        if (store_edge) err_set = 1'b1;
      end
      ST_RUNNING: begin
        if (store_edge || go_edge) err_set = 1'b1;
        // Busy fell after being seen, or never showed up within the grace window.
        if (!cracker_busy && (busy_seen || wait_cnt == 2'd2)) begin
          done    = 1'b1;
          state_d = ST_LOADING;
        end
      end
      default: state_d = ST_LOADING;
    endcase
  end

  // Byte assembly, start pulse, error flag and cracker-handshake tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_hash <= '0;
      byte_count  <= '0;
      start       <= 1'b0;
      load_error  <= 1'b0;
      busy_seen   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      start <= fire;
      if (wr_byte) begin
        target_hash[{byte_count[3:0], 3'b000} +: 8] <= new_hash_byte;
        byte_count <= byte_count + 5'd1;
      end
      if (done) begin
        byte_count <= '0;
        load_error <= 1'b0;
      end else if (err_set) begin
        load_error <= 1'b1;
      end
      if (fire) begin
        busy_seen <= 1'b0;
        wait_cnt  <= '0;
      end else if (state_q == ST_RUNNING) begin
        if (cracker_busy)      busy_seen <= 1'b1;
        if (wait_cnt != 2'd2)  wait_cnt  <= wait_cnt + 2'd1;
      end
    end
  end

  assign hash_valid = (state_q != ST_LOADING);
endmodule
